// File: rtl/jbi_ncio_mack_sched_pkg.sv
// rtl/jbi_ncio_mack_sched_pkg.sv - shared constants, entry type and issue FSM encodings for the mondo ack scheduler
// Purpose : ack-queue entry field positions, queue address width and the
//           one-hot issue FSM encodings used by jbi_ncio_mack_sched and
//           jbi_ncio_mack_fifo.
// Ports   : none (package).
// Config  : JBI_MACK_ERRLOG_EN is consumed by jbi_ncio_mack_sched only.
package jbi_ncio_mack_sched_pkg;

    localparam int JBI_MAKQ_WIDTH      = 10;
    localparam int JBI_MAKQ_CPUID_HI   = 9;
    localparam int JBI_MAKQ_CPUID_LO   = 5;
    localparam int JBI_MAKQ_AGTID_HI   = 4;
    localparam int JBI_MAKQ_AGTID_LO   = 0;
    localparam int JBI_MACK_ADDR_WIDTH = 4;
    localparam int JBI_MACK_DEPTH      = 1 << JBI_MACK_ADDR_WIDTH;

    // One-hot issue FSM
    typedef enum logic [1:0] {
        JBI_MACK_IDLE = 2'b01,
        JBI_MACK_REQ  = 2'b10
    } jbi_mack_state_e;

    typedef struct packed {
        logic [4:0] cpuid;
        logic [4:0] agtid;
        logic       nack;
        logic       rslv;
    } jbi_mack_entry_t;

endpackage

// File: rtl/jbi_ncio_mack_fifo.sv
// rtl/jbi_ncio_mack_fifo.sv - flop-based ack-queue entry array with push, resolve and pop ports
// Purpose : holds ack-queue entries; pointer bookkeeping lives in the parent.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           i_push_*            - write a whole entry (pending or pre-resolved NACK)
//           i_rslv_*            - mark an entry resolved with the IOB outcome
//           i_pop_*             - clear rslv of the consumed head entry
//           i_rd_idx/o_rd_entry - combinational head read
module jbi_ncio_mack_fifo
    import jbi_ncio_mack_sched_pkg::*;
#(
    parameter int DEPTH = JBI_MACK_DEPTH,
    parameter int AW    = JBI_MACK_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push_en,
    input  logic [AW-1:0]             i_push_idx,
    input  logic [JBI_MAKQ_WIDTH-1:0] i_push_data,
    input  logic                      i_push_nack,
    input  logic                      i_rslv_en,
    input  logic [AW-1:0]             i_rslv_idx,
    input  logic                      i_rslv_nack,
    input  logic                      i_pop_en,
    input  logic [AW-1:0]             i_pop_idx,
    input  logic [AW-1:0]             i_rd_idx,
    output jbi_mack_entry_t           o_rd_entry
);

    jbi_mack_entry_t r_ent [DEPTH];

    // The three write ports never target the same slot in legal operation:
    // push goes to the free tail, resolve to an unresolved (never head-popped)
    // entry, pop to the resolved head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (i_pop_en) begin
                r_ent[i_pop_idx].rslv <= 1'b0;
            end
            if (i_push_en) begin
                r_ent[i_push_idx] <= '{cpuid: i_push_data[JBI_MAKQ_CPUID_HI:JBI_MAKQ_CPUID_LO],
                                       agtid: i_push_data[JBI_MAKQ_AGTID_HI:JBI_MAKQ_AGTID_LO],
                                       nack:  i_push_nack,
                                       rslv:  i_push_nack};
            end
            if (i_rslv_en) begin
                r_ent[i_rslv_idx].rslv <= 1'b1;
                r_ent[i_rslv_idx].nack <= i_rslv_nack;
            end
        end
    end

    assign o_rd_entry = r_ent[i_rd_idx];

endmodule

// File: rtl/jbi_ncio_mack_sched.sv
// rtl/jbi_ncio_mack_sched.sv - in-order mondo INT_ACK/INT_NACK scheduler toward the JBus arbiter
// Purpose : buffers ack-queue entries, resolves the pending one from the IOB
//           response and issues resolved entries oldest-first via req/gnt.
// Ports   : clk, rst                        - clock, synchronous active-high reset
//           makq_push/makq_wdata/makq_nack  - entry enqueue
//           iob_jbi_mondo_ack_ff/nack_ff    - IOB outcome for the pending entry
//           mack_req/mack_gnt               - arbiter handshake
//           mack_nack/agtid/cpuid           - head entry presented with mack_req
//           mack_full                       - all DEPTH entries occupied
//           mack_err_status/mack_err_clr    - sticky protocol errors
// Config  : `define JBI_MACK_ERRLOG_EN to enable the sticky error log;
//           otherwise mack_err_status is 0 and mack_err_clr is ignored.
module jbi_ncio_mack_sched
    import jbi_ncio_mack_sched_pkg::*;
#(
    parameter int DEPTH = JBI_MACK_DEPTH,
    parameter int AW    = JBI_MACK_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      makq_push,
    input  logic [JBI_MAKQ_WIDTH-1:0] makq_wdata,
    input  logic                      makq_nack,
    input  logic                      iob_jbi_mondo_ack_ff,
    input  logic                      iob_jbi_mondo_nack_ff,
    output logic                      mack_req,
    input  logic                      mack_gnt,
    output logic                      mack_nack,
    output logic [4:0]                mack_agtid,
    output logic [4:0]                mack_cpuid,
    output logic                      mack_full,
    output logic [2:0]                mack_err_status,
    input  logic                      mack_err_clr
);

    logic [AW:0]     r_wptr, r_rptr;
    logic            r_pend_vld;
    logic [AW-1:0]   r_pend_idx;
    logic            r_full;
    jbi_mack_state_e r_state;
    logic            r_req, r_nack;
    logic [4:0]      r_agtid, r_cpuid;

    logic            w_rsp, w_resolve, w_push_ok, w_pop;
    logic [AW:0]     w_wptr_nxt, w_rptr_nxt;
    logic            w_full_nxt;
    jbi_mack_entry_t w_head;
    logic            w_head_vld, w_head_hit, w_head_rdy, w_head_nack;
    logic [4:0]      w_head_agtid, w_head_cpuid;

    assign w_rsp      = iob_jbi_mondo_ack_ff | iob_jbi_mondo_nack_ff;
    assign w_resolve  = w_rsp & r_pend_vld;
    assign w_push_ok  = makq_push & ~r_full;
    assign w_pop      = r_req & mack_gnt;
    assign w_wptr_nxt = r_wptr + (AW+1)'(w_push_ok);
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);
    assign w_full_nxt = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                        (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

    jbi_ncio_mack_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push_en   (w_push_ok),
        .i_push_idx  (r_wptr[AW-1:0]),
        .i_push_data (makq_wdata),
        .i_push_nack (makq_nack),
        .i_rslv_en   (w_resolve),
        .i_rslv_idx  (r_pend_idx),
        .i_rslv_nack (iob_jbi_mondo_nack_ff),
        .i_pop_en    (w_pop),
        .i_pop_idx   (r_rptr[AW-1:0]),
        .i_rd_idx    (r_rptr[AW-1:0]),
        .o_rd_entry  (w_head)
    );

    // Head readiness looks through this cycle's resolve and, on an empty
    // queue, this cycle's NACK push, so mack_req rises one cycle after either.
    assign w_head_vld = (r_rptr != r_wptr);
    assign w_head_hit = w_resolve && (r_pend_idx == r_rptr[AW-1:0]);

    always_comb begin
        w_head_rdy   = 1'b0;
        w_head_nack  = w_head.nack;
        w_head_agtid = w_head.agtid;
        w_head_cpuid = w_head.cpuid;
        if (w_head_vld) begin
            if (w_head.rslv) begin
                w_head_rdy = 1'b1;
            end else if (w_head_hit) begin
                w_head_rdy  = 1'b1;
                w_head_nack = iob_jbi_mondo_nack_ff;
            end
        end else if (w_push_ok && makq_nack) begin
            w_head_rdy   = 1'b1;
            w_head_nack  = 1'b1;
            w_head_agtid = makq_wdata[JBI_MAKQ_AGTID_HI:JBI_MAKQ_AGTID_LO];
            w_head_cpuid = makq_wdata[JBI_MAKQ_CPUID_HI:JBI_MAKQ_CPUID_LO];
        end
    end

    // Pointers, pending tracker, full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_full     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_full <= w_full_nxt;
            // A pending push in the same cycle as a resolve leaves the new
            // entry as the one awaiting the IOB.
            if (w_push_ok && !makq_nack) begin
                r_pend_vld <= 1'b1;
                r_pend_idx <= r_wptr[AW-1:0];
            end else if (w_resolve) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Issue FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= JBI_MACK_IDLE;
            r_req   <= 1'b0;
            r_nack  <= 1'b0;
            r_agtid <= '0;
            r_cpuid <= '0;
        end else begin
            case (r_state)
                JBI_MACK_IDLE: begin
                    if (w_head_rdy) begin
                        r_state <= JBI_MACK_REQ;
                        r_req   <= 1'b1;
                        r_nack  <= w_head_nack;
                        r_agtid <= w_head_agtid;
                        r_cpuid <= w_head_cpuid;
                    end
                end
                JBI_MACK_REQ: begin
                    if (mack_gnt) begin
                        r_state <= JBI_MACK_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= JBI_MACK_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign mack_req   = r_req;
    assign mack_nack  = r_nack;
    assign mack_agtid = r_agtid;
    assign mack_cpuid = r_cpuid;
    assign mack_full  = r_full;

`ifdef JBI_MACK_ERRLOG_EN
    logic [2:0] r_err;
    logic [2:0] w_err_ev;

    // [0] overflow or pending push over an unresolved pending entry
    // [1] ack and nack together, [2] response with nothing pending
    assign w_err_ev[0] = makq_push & (r_full | (~makq_nack & r_pend_vld & ~w_rsp));
    assign w_err_ev[1] = w_resolve & iob_jbi_mondo_ack_ff & iob_jbi_mondo_nack_ff;
    assign w_err_ev[2] = w_rsp & ~r_pend_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= (mack_err_clr ? 3'b000 : r_err) | w_err_ev;
        end
    end

    assign mack_err_status = r_err;
`else
    logic w_unused;
    assign w_unused        = mack_err_clr;
    assign mack_err_status = 3'b000;
`endif

endmodule

// File: tb/tb_jbi_ncio_mack_sched.sv
// tb/tb_jbi_ncio_mack_sched.sv - self-checking bench for jbi_ncio_mack_sched
module tb_jbi_ncio_mack_sched;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       makq_push = 1'b0;
    logic [9:0] makq_wdata = '0;
    logic       makq_nack = 1'b0;
    logic       iob_ack = 1'b0;
    logic       iob_nack = 1'b0;
    logic       mack_gnt = 1'b0;
    logic       mack_err_clr = 1'b0;
    logic       mack_req, mack_nack, mack_full;
    logic [4:0] mack_agtid, mack_cpuid;
    logic [2:0] mack_err_status;

    int n_checks = 0;
    int n_errors = 0;

    jbi_ncio_mack_sched dut (
        .clk                   (clk),
        .rst                   (rst),
        .makq_push             (makq_push),
        .makq_wdata            (makq_wdata),
        .makq_nack             (makq_nack),
        .iob_jbi_mondo_ack_ff  (iob_ack),
        .iob_jbi_mondo_nack_ff (iob_nack),
        .mack_req              (mack_req),
        .mack_gnt              (mack_gnt),
        .mack_nack             (mack_nack),
        .mack_agtid            (mack_agtid),
        .mack_cpuid            (mack_cpuid),
        .mack_full             (mack_full),
        .mack_err_status       (mack_err_status),
        .mack_err_clr          (mack_err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of outstanding mondo acks
    typedef struct {
        logic [4:0] cpuid;
        logic [4:0] agtid;
        bit         nack;
        bit         rslv;
        int         id;
    } ment_t;

    ment_t      mq[$];
    bit         m_pend_vld = 0;
    int         m_pend_id  = 0;
    int         m_next_id  = 0;
    bit         e_req = 0;
    bit         e_nack = 0;
    logic [4:0] e_agtid = '0;
    logic [4:0] e_cpuid = '0;
    logic [2:0] e_err = '0;

    function automatic logic [2:0] exp_err();
`ifdef JBI_MACK_ERRLOG_EN
        return e_err;
`else
        return 3'b000;
`endif
    endfunction

    task automatic model_tick();
        bit rsp, full;
        logic [2:0] ev;
        ment_t e;
        if (rst) begin
            mq.delete();
            m_pend_vld = 0;
            e_req = 0; e_nack = 0; e_agtid = '0; e_cpuid = '0; e_err = '0;
            return;
        end
        rsp  = iob_ack | iob_nack;
        full = (mq.size() == DEPTH);
        ev   = '0;
        if (rsp && !m_pend_vld) ev[2] = 1'b1;
        if (rsp && m_pend_vld && iob_ack && iob_nack) ev[1] = 1'b1;
        if (makq_push && (full || (!makq_nack && m_pend_vld && !rsp))) ev[0] = 1'b1;
        if (e_req && mack_gnt) e = mq.pop_front();
        if (rsp && m_pend_vld) begin
            foreach (mq[i]) begin
                if (mq[i].id == m_pend_id) begin
                    mq[i].rslv = 1;
                    mq[i].nack = iob_nack;
                end
            end
            m_pend_vld = 0;
        end
        if (makq_push && !full) begin
            e.cpuid = makq_wdata[9:5];
            e.agtid = makq_wdata[4:0];
            e.nack  = makq_nack;
            e.rslv  = makq_nack;
            e.id    = m_next_id;
            m_next_id++;
            mq.push_back(e);
            if (!makq_nack) begin
                m_pend_vld = 1;
                m_pend_id  = e.id;
            end
        end
        if (e_req) begin
            if (mack_gnt) e_req = 0;
        end else if (mq.size() > 0 && mq[0].rslv) begin
            e_req   = 1;
            e_nack  = mq[0].nack;
            e_agtid = mq[0].agtid;
            e_cpuid = mq[0].cpuid;
        end
        e_err = (mack_err_clr ? 3'b000 : e_err) | ev;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample at +1
    task automatic step(input bit p, input logic [9:0] d, input bit n,
                        input bit a, input bit k, input bit g, input bit c);
        makq_push = p; makq_wdata = d; makq_nack = n;
        iob_ack = a; iob_nack = k; mack_gnt = g; mack_err_clr = c;
        @(posedge clk);
        model_tick();
        #1;
        makq_push = 0; makq_wdata = '0; makq_nack = 0;
        iob_ack = 0; iob_nack = 0; mack_gnt = 0; mack_err_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        idle(2);
        rst = 0;
        n_checks++;
        if ({mack_req, mack_nack, mack_agtid, mack_cpuid, mack_full, mack_err_status} !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got req=%0b nack=%0b agt=%0d cpu=%0d full=%0b err=%b, want all 0",
                     mack_req, mack_nack, mack_agtid, mack_cpuid, mack_full, mack_err_status);
        end
        idle(1);
        n_checks++;
        if (mack_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_req: got %0b want 0", mack_req);
        end
    endtask

    task automatic test_basic_ack();
        step(1, {5'd3, 5'd5}, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (mack_req !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_wait_req cyc%0d: got %0b want 0", i, mack_req);
            end
            step(0, '0, 0, 0, 0, 0, 0);
        end
        step(0, '0, 0, 1, 0, 0, 0);
        n_checks++;
        if ({mack_req, mack_nack, mack_agtid, mack_cpuid} !== {1'b1, 1'b0, 5'd5, 5'd3}) begin
            n_errors++;
            $display("FAIL basic_issue: got req=%0b nack=%0b agt=%0d cpu=%0d want req=1 nack=0 agt=5 cpu=3",
                     mack_req, mack_nack, mack_agtid, mack_cpuid);
        end
        idle(2);
        n_checks++;
        if ({mack_req, mack_agtid, mack_cpuid} !== {1'b1, 5'd5, 5'd3}) begin
            n_errors++;
            $display("FAIL basic_hold: got req=%0b agt=%0d cpu=%0d want 1/5/3", mack_req, mack_agtid, mack_cpuid);
        end
        step(0, '0, 0, 0, 0, 1, 0);
        n_checks++;
        if (mack_req !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_after_gnt: got req=%0b want 0", mack_req);
        end
        idle(2);
        n_checks++;
        if (mack_req !== 1'b0 || mack_full !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_empty: got req=%0b full=%0b want 0/0", mack_req, mack_full);
        end
    endtask

    task automatic test_order_block();
        step(1, {5'd1, 5'd2}, 0, 0, 0, 0, 0);
        step(1, {5'd7, 5'd8}, 1, 0, 0, 0, 0);
        idle(3);
        n_checks++;
        if (mack_req !== 1'b0) begin
            n_errors++;
            $display("FAIL order_blocked: got req=%0b want 0", mack_req);
        end
        step(0, '0, 0, 0, 1, 0, 0);
        n_checks++;
        if ({mack_req, mack_nack, mack_cpuid, mack_agtid} !== {1'b1, 1'b1, 5'd1, 5'd2}) begin
            n_errors++;
            $display("FAIL order_first: got req=%0b nack=%0b cpu=%0d agt=%0d want 1/1/1/2",
                     mack_req, mack_nack, mack_cpuid, mack_agtid);
        end
        step(0, '0, 0, 0, 0, 1, 0);
        n_checks++;
        if (mack_req !== 1'b0) begin
            n_errors++;
            $display("FAIL order_gap: got req=%0b want 0", mack_req);
        end
        step(0, '0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({mack_req, mack_nack, mack_cpuid, mack_agtid} !== {1'b1, 1'b1, 5'd7, 5'd8}) begin
            n_errors++;
            $display("FAIL order_second: got req=%0b nack=%0b cpu=%0d agt=%0d want 1/1/7/8",
                     mack_req, mack_nack, mack_cpuid, mack_agtid);
        end
        step(0, '0, 0, 0, 0, 1, 0);
        idle(1);
    endtask

    task automatic test_full();
        int idx;
        step(0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, {5'(i), 5'(~i)}, 1, 0, 0, 0, 0);
            if (i == DEPTH - 2) begin
                n_checks++;
                if (mack_full !== 1'b0) begin
                    n_errors++;
                    $display("FAIL full_early: got full=%0b want 0 after 15 pushes", mack_full);
                end
            end
        end
        n_checks++;
        if (mack_full !== 1'b1) begin
            n_errors++;
            $display("FAIL full_flag: got full=%0b want 1", mack_full);
        end
        step(1, {5'd31, 5'd31}, 1, 0, 0, 0, 0);
        n_checks++;
        if (mack_full !== 1'b1 || mack_err_status !== exp_err()) begin
            n_errors++;
            $display("FAIL full_overflow: got full=%0b err=%b want full=1 err=%b",
                     mack_full, mack_err_status, exp_err());
        end
        idx = 0;
        for (int cyc = 0; cyc < 100 && idx < DEPTH; cyc++) begin
            if (mack_req === 1'b1) begin
                n_checks++;
                if (mack_cpuid !== 5'(idx) || mack_agtid !== 5'(~idx)) begin
                    n_errors++;
                    $display("FAIL full_drain%0d: got cpu=%0d agt=%0d want cpu=%0d agt=%0d",
                             idx, mack_cpuid, mack_agtid, idx, 5'(~idx));
                end
                step(0, '0, 0, 0, 0, 1, 0);
                idx++;
            end else begin
                step(0, '0, 0, 0, 0, 0, 0);
            end
        end
        idle(3);
        n_checks++;
        if (idx != DEPTH || mack_req !== 1'b0 || mack_full !== 1'b0) begin
            n_errors++;
            $display("FAIL full_drained: got grants=%0d req=%0b full=%0b want 16/0/0", idx, mack_req, mack_full);
        end
        step(0, '0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_collision();
        step(1, {5'd4, 5'd6}, 0, 0, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0, 0);
        n_checks++;
        if ({mack_req, mack_nack, mack_cpuid} !== {1'b1, 1'b1, 5'd4} || mack_err_status !== exp_err()) begin
            n_errors++;
            $display("FAIL collision: got req=%0b nack=%0b cpu=%0d err=%b want 1/1/4 err=%b",
                     mack_req, mack_nack, mack_cpuid, mack_err_status, exp_err());
        end
        step(0, '0, 0, 0, 0, 1, 0);
        step(0, '0, 0, 0, 0, 0, 1);
        idle(1);
    endtask

    task automatic test_orphan();
        step(0, '0, 0, 1, 0, 0, 0);
        n_checks++;
        if (mack_req !== 1'b0 || mack_full !== 1'b0 || mack_err_status !== exp_err()) begin
            n_errors++;
            $display("FAIL orphan: got req=%0b full=%0b err=%b want 0/0 err=%b",
                     mack_req, mack_full, mack_err_status, exp_err());
        end
        step(0, '0, 0, 0, 0, 0, 1);
        n_checks++;
        if (mack_err_status !== 3'b000) begin
            n_errors++;
            $display("FAIL orphan_clear: got err=%b want 000", mack_err_status);
        end
        idle(2);
        n_checks++;
        if (mack_req !== 1'b0) begin
            n_errors++;
            $display("FAIL orphan_no_issue: got req=%0b want 0", mack_req);
        end
    endtask

    task automatic test_reset_mid();
        step(1, {5'd20, 5'd1}, 1, 0, 0, 0, 0);
        step(1, {5'd21, 5'd2}, 1, 0, 0, 0, 0);
        step(1, {5'd22, 5'd3}, 1, 0, 0, 0, 0);
        n_checks++;
        if (mack_req !== 1'b1 || mack_cpuid !== 5'd20) begin
            n_errors++;
            $display("FAIL rstmid_req: got req=%0b cpu=%0d want 1/20", mack_req, mack_cpuid);
        end
        rst = 1;
        step(0, '0, 0, 0, 0, 0, 0);
        rst = 0;
        n_checks++;
        if (mack_req !== 1'b0 || mack_full !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_after: got req=%0b full=%0b want 0/0", mack_req, mack_full);
        end
        idle(2);
        n_checks++;
        if (mack_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_flushed: got req=%0b want 0", mack_req);
        end
        step(1, {5'd9, 5'd1}, 1, 0, 0, 0, 0);
        n_checks++;
        if ({mack_req, mack_cpuid, mack_agtid} !== {1'b1, 5'd9, 5'd1}) begin
            n_errors++;
            $display("FAIL rstmid_restart: got req=%0b cpu=%0d agt=%0d want 1/9/1", mack_req, mack_cpuid, mack_agtid);
        end
        step(0, '0, 0, 0, 0, 1, 0);
        idle(2);
    endtask

    task automatic test_random();
        bit p, n, a, k, g, c, rsp;
        int issued;
        issued = 0;
        rst = 1;
        idle(1);
        rst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rsp = m_pend_vld ? ($urandom_range(99) < 25) : ($urandom_range(99) < 2);
            a = 0; k = 0;
            if (rsp) begin
                case ($urandom_range(9))
                    0:       begin a = 1; k = 1; end
                    1, 2, 3: k = 1;
                    default: a = 1;
                endcase
            end
            p = ($urandom_range(99) < 45);
            n = ($urandom_range(99) < 50);
            if (p && !n && m_pend_vld && !rsp) n = 1;
            g = ($urandom_range(99) < 35);
            c = ($urandom_range(99) < 4);
            if (e_req && g) issued++;
            step(p, 10'($urandom), n, a, k, g, c);
            n_checks++;
            if (mack_req !== e_req || mack_full !== (mq.size() == DEPTH) ||
                mack_err_status !== exp_err() ||
                (e_req && {mack_nack, mack_agtid, mack_cpuid} !== {e_nack, e_agtid, e_cpuid})) begin
                n_errors++;
                $display("FAIL random cyc%0d: got req=%0b nack=%0b agt=%0d cpu=%0d full=%0b err=%b want req=%0b nack=%0b agt=%0d cpu=%0d full=%0b err=%b",
                         cyc, mack_req, mack_nack, mack_agtid, mack_cpuid, mack_full, mack_err_status,
                         e_req, e_nack, e_agtid, e_cpuid, (mq.size() == DEPTH), exp_err());
            end
        end
        n_checks++;
        if (issued < 50) begin
            n_errors++;
            $display("FAIL random_progress: got %0d grants want at least 50", issued);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic_ack();
        test_order_block();
        test_full();
        test_collision();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
